// File: rtl/fp_add_norm_round.sv
`default_nettype none
// ============================================================================
// Module  : fp_add_norm_round
// Purpose : FP adder back end - normalise, round-to-nearest-even, pack; 2-stage valid/ready pipe
// Rev     : 1.0
// ============================================================================
module fp_add_norm_round #(
  parameter int MAN_W = 10,
  parameter int EXP_W = 5,
  localparam int SUM_W = MAN_W + 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [EXP_W-1:0]     in_exp,
  input  logic [SUM_W-1:0]     in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_result,
  output logic [3:0]           out_flags
);

  localparam int LZ_W = $clog2(SUM_W);
  typedef logic signed [EXP_W+1:0] sexp_t;
  localparam sexp_t c_exp_max = sexp_t'((1 << EXP_W) - 1);
  localparam logic [MAN_W-1:0] c_qnan_frac = {1'b1, {(MAN_W-1){1'b0}}};

  // ---------------- stage 1: normalise ----------------
  logic [SUM_W-2:0] w_lo;
  logic [SUM_W-2:0] w_shl;
  logic [LZ_W-1:0]  w_lzc;
  logic [MAN_W:0]   w_n_man;
  logic [2:0]       w_n_grs;
  sexp_t            w_exp_in;
  sexp_t            w_n_exp;
  logic             w_in_fire;
  logic             w_s1_adv;

  logic             r_s1_v;
  logic             r_s1_sign;
  sexp_t            r_s1_exp;
  logic [MAN_W-1:0] r_s1_frac;
  logic [2:0]       r_s1_grs;
  logic             r_s1_zero;
  logic             r_s1_spec;
  logic             r_s1_nan;

  assign w_lo     = in_sum[SUM_W-2:0];
  assign w_exp_in = sexp_t'(in_exp);

  always_comb begin
    w_lzc = LZ_W'(SUM_W - 1);
    for (int i = 0; i < SUM_W - 1; i++) begin
      if (w_lo[i]) w_lzc = LZ_W'(SUM_W - 2 - i);
    end
  end

  assign w_shl = w_lo << w_lzc;

  always_comb begin
    if (in_sum[SUM_W-1]) begin
      w_n_man = in_sum[SUM_W-1:SUM_W-1-MAN_W];
      w_n_grs = {in_sum[3], in_sum[2], |in_sum[1:0]};
      w_n_exp = w_exp_in + sexp_t'(1);
    end else begin
      w_n_man = w_shl[SUM_W-2:3];
      w_n_grs = w_shl[2:0];
      w_n_exp = w_exp_in - sexp_t'(w_lzc);
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic                 r_s2_v;
  logic [EXP_W+MAN_W:0] r_out_result;
  logic [3:0]           r_out_flags;
  logic                 w_round_up;
  logic                 w_rnd_cy;
  logic [MAN_W-1:0]     w_frac_rnd;
  sexp_t                w_exp_rnd;
  logic [EXP_W+MAN_W:0] w_res;
  logic [3:0]           w_flags;

  assign w_round_up = r_s1_grs[2] & (r_s1_grs[1] | r_s1_grs[0] | r_s1_frac[0]);
  // A carry out of the fraction means 1.11..1 rounded up to 10.0: fraction is already 0
  assign {w_rnd_cy, w_frac_rnd} = {1'b0, r_s1_frac} + (MAN_W+1)'(w_round_up);
  assign w_exp_rnd = r_s1_exp + sexp_t'(w_rnd_cy);

  always_comb begin
    w_res   = {r_s1_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
    w_flags = {2'b00, |r_s1_grs, 1'b0};
    if (r_s1_spec) begin
      w_res   = {r_s1_sign, {EXP_W{1'b1}}, (r_s1_nan ? c_qnan_frac : {MAN_W{1'b0}})};
      w_flags = 4'b0000;
    end else if (r_s1_zero) begin
      w_res   = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
      w_flags = 4'b0001;
    end else if (w_exp_rnd >= c_exp_max) begin
      w_res   = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_flags = 4'b1010;
    end else if (w_exp_rnd <= sexp_t'(0)) begin
      w_res   = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
      w_flags = 4'b0111;
    end
  end

  // ---------------- handshake ----------------
  assign in_ready  = !rst_n || !r_s1_v || !r_s2_v || out_ready;
  assign w_in_fire = in_valid && in_ready;
  assign w_s1_adv  = r_s1_v && (!r_s2_v || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v       <= 1'b0;
      r_s1_sign    <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_frac    <= '0;
      r_s1_grs     <= '0;
      r_s1_zero    <= 1'b0;
      r_s1_spec    <= 1'b0;
      r_s1_nan     <= 1'b0;
      r_s2_v       <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
    end else begin
      if (w_in_fire) begin
        r_s1_sign <= in_sign;
        r_s1_exp  <= w_n_exp;
        r_s1_frac <= w_n_man[MAN_W-1:0];
        r_s1_grs  <= w_n_grs;
        r_s1_zero <= !w_n_man[MAN_W];
        r_s1_spec <= &in_exp;
        r_s1_nan  <= |in_sum[MAN_W+2:3];
      end
      r_s1_v <= w_in_fire || (r_s1_v && !w_s1_adv);

      if (w_s1_adv) begin
        r_s2_v       <= 1'b1;
        r_out_result <= w_res;
        r_out_flags  <= w_flags;
      end else if (out_ready) begin
        r_s2_v <= 1'b0;
      end
    end
  end

  assign out_valid  = r_s2_v;
  assign out_result = r_out_result;
  assign out_flags  = r_out_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_norm_round.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_add_norm_round
// Purpose : scoreboard bench for the FP adder normalise/round back end
// Rev     : 1.0
// ============================================================================
module tb_fp_add_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [4:0]  in_exp = '0;
  logic [14:0] in_sum = '0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_result;
  logic [3:0]  out_flags;

  int n_checks  = 0;
  int n_errors  = 0;
  int n_emitted = 0;

  typedef struct {
    logic        s;
    logic [4:0]  e;
    logic [14:0] sum;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t        vt[$];
  logic [19:0] exp_q[$];
  logic        send_done = 1'b0;

  fp_add_norm_round #(.MAN_W(10), .EXP_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: pops on every output handshake, checks holding while stalled
  logic        stall_q = 1'b0;
  logic [19:0] held_q  = '0;
  always @(negedge clk) begin
    logic [19:0] e;
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        n_checks++;
        if ({out_valid, out_result, out_flags} !== {1'b1, held_q}) begin
          n_errors++;
          $display("FAIL hold: got v=%b %h/%h required v=1 %h/%h",
                   out_valid, out_result, out_flags, held_q[19:4], held_q[3:0]);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        n_emitted++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_output: got %h/%h required no output", out_result, out_flags);
        end else begin
          e = exp_q.pop_front();
          if ({out_result, out_flags} !== e) begin
            n_errors++;
            $display("FAIL result: got %h flags %b required %h flags %b",
                     out_result, out_flags, e[19:4], e[3:0]);
          end
        end
      end
      stall_q = out_valid && !out_ready;
      held_q  = {out_result, out_flags};
    end
  end

  function automatic void add(input logic s, input logic [4:0] e, input logic [14:0] sum,
                              input logic [15:0] res, input logic [3:0] fl);
    vec_t v;
    v.s = s; v.e = e; v.sum = sum; v.res = res; v.fl = fl;
    vt.push_back(v);
  endfunction

  // Call at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input vec_t v, output int waits);
    in_valid = 1'b1;
    in_sign  = v.s;
    in_exp   = v.e;
    in_sum   = v.sum;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready=0 required 1 within 200 cycles");
    end else begin
      exp_q.push_back({v.res, v.fl});
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0 || out_valid) begin
      n_errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    n_checks++;
    if (out_result !== 16'h0000) begin n_errors++; $display("FAIL reset_result: got %h required 0000", out_result); end
    n_checks++;
    if (out_flags !== 4'h0) begin n_errors++; $display("FAIL reset_flags: got %b required 0000", out_flags); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int w;
    out_ready = 1'b1;
    send(vt[0], w);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL latency_early: got out_valid=%b required 0", out_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h4000 || out_flags !== 4'h0) begin
      n_errors++;
      $display("FAIL latency_2cyc: got v=%b %h/%b required v=1 4000/0000", out_valid, out_result, out_flags);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    out_ready = 1'b1;
    foreach (vt[i]) begin
      send(vt[i], w);
      n_checks++;
      if (w != 0) begin n_errors++; $display("FAIL no_bubble: got %0d wait cycles required 0 (vec %0d)", w, i); end
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_backpressure();
    int w;
    int n0;
    n0 = n_emitted;
    out_ready = 1'b0;
    send(vt[2], w);
    send(vt[3], w);
    in_valid = 1'b1;
    in_sign  = vt[4].s;
    in_exp   = vt[4].e;
    in_sum   = vt[4].sum;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== vt[2].res) begin
      n_errors++;
      $display("FAIL bp_head: got v=%b %h required v=1 %h", out_valid, out_result, vt[2].res);
    end
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(vt[4], w);
    in_valid = 1'b0;
    drain();
    n_checks++;
    if (n_emitted - n0 != 3) begin n_errors++; $display("FAIL bp_count: got %0d outputs required 3", n_emitted - n0); end
  endtask

  task automatic test_reset_midflight();
    int w;
    int n0;
    out_ready = 1'b0;
    send(vt[0], w);
    send(vt[1], w);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 16'h0000) begin
      n_errors++;
      $display("FAIL midreset: got v=%b %h required v=0 0000", out_valid, out_result);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n0 = n_emitted;
    send(vt[5], w);
    in_valid = 1'b0;
    drain();
    n_checks++;
    if (n_emitted - n0 != 1) begin n_errors++; $display("FAIL post_reset_count: got %0d outputs required 1", n_emitted - n0); end
  endtask

  task automatic test_random_stall();
    int w;
    send_done = 1'b0;
    fork
      begin
        for (int r = 0; r < 2; r++) begin
          foreach (vt[i]) send(vt[i], w);
        end
        in_valid = 1'b0;
        send_done = 1'b1;
      end
      begin
        for (int k = 0; k < 400 && !send_done; k++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // {sign, exp, sum} -> {result, {ovf,unf,inx,zero}}
    add(0, 5'd15, 15'h4000, 16'h4000, 4'b0000);
    add(0, 5'd15, 15'h1000, 16'h3800, 4'b0000);
    add(0, 5'd15, 15'h2004, 16'h3C00, 4'b0010);
    add(0, 5'd15, 15'h200C, 16'h3C02, 4'b0010);
    add(0, 5'd15, 15'h3FFC, 16'h4000, 4'b0010);
    add(0, 5'd30, 15'h4000, 16'h7C00, 4'b1010);
    add(0, 5'd1,  15'h0800, 16'h0000, 4'b0111);
    add(1, 5'd10, 15'h0000, 16'h8000, 4'b0001);
    add(1, 5'd31, 15'h2000, 16'hFC00, 4'b0000);
    add(0, 5'd31, 15'h2008, 16'h7E00, 4'b0000);
    add(0, 5'd15, 15'h4008, 16'h4000, 4'b0010);
    add(0, 5'd15, 15'h4009, 16'h4001, 4'b0010);
    add(0, 5'd15, 15'h4018, 16'h4002, 4'b0010);
    add(0, 5'd30, 15'h3FFC, 16'h7C00, 4'b1010);
    add(0, 5'd1,  15'h2000, 16'h0400, 4'b0000);
    add(1, 5'd1,  15'h1000, 16'h8000, 4'b0111);
    add(0, 5'd30, 15'h3FF8, 16'h7BFF, 4'b0000);
    add(1, 5'd15, 15'h0001, 16'h8800, 4'b0000);
    add(0, 5'd31, 15'h0004, 16'h7C00, 4'b0000);
    add(0, 5'd0,  15'h4000, 16'h0400, 4'b0000);

    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random_stall();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
